sd_block_arbiter: RTL and testbench
===================================

Name: sd_block_arbiter

Overview:
- Shares one SD controller between two block requesters:
  - port 0: instruction-fetch/boot loader;
  - port 1: data memory / test driver.
- Grants one requester at a time using round-robin priority.
- Sequences the controller's rd/wr/busy handshake and returns the 512-byte block with a per-port ack.
- A watchdog converts a hung controller transaction into an error-ack, so no requester stalls forever.
- Sits between the memory bus adapters and the sd_controller block.

Parameters:
- BlockBits, 4096, width of one SD data block.
- AddrBits, 32, width of the block address.
- TimeoutCycles, 1_000_000, maximum cycles from issue to completion before an error-ack.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- p0_rd_en  in  1  port 0 read request; held until p0_ack
- p0_wr_en  in  1  port 0 write request; held until p0_ack
- p0_addr  in  AddrBits  port 0 block address
- p0_write_data  in  BlockBits  port 0 write block
- p0_ack  out  1  port 0 completion pulse
- p1_rd_en, p1_wr_en, p1_addr, p1_write_data, p1_ack: same as port 0, for port 1
- read_data  out  BlockBits  block read by the last read; valid with any ack
- error  out  1  qualifies an ack as timeout-failed
- sd_rd_en  out  1  controller read strobe
- sd_wr_en  out  1  controller write strobe
- sd_addr  out  AddrBits  controller block address
- sd_write_data  out  BlockBits  controller write block
- sd_read_data  in  BlockBits  controller read block
- sd_busy  in  1  high while the controller executes an operation

Behaviour:
- Reset (async, reset_n=0):
  - state=Idle.
  - All outputs 0: sd_rd_en, sd_wr_en, sd_addr, sd_write_data, read_data, p0_ack, p1_ack, error.
  - last_grant=1, so port 0 wins the first tie.
  - Timeout counter=0.
  - Reset mid-transaction abandons it: no ack is issued; the requester must re-request.
- Request decode per port: req = rd_en | wr_en.
  - rd_en and wr_en both high is treated as a read.
- Idle:
  - No req: stay.
  - One req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch addr, write_data and op type into the sd_* registers; go Issue.
- Issue (1 cycle):
  - sd_rd_en or sd_wr_en = 1 for exactly this cycle.
  - Clear the counter; go WaitBusy.
- WaitBusy:
  - Wait for sd_busy=1, then go WaitDone.
  - If sd_busy is already high in the Issue cycle, it is accepted the next cycle.
- WaitDone:
  - Wait for sd_busy=0.
  - Then capture sd_read_data into read_data (reads only; writes leave read_data unchanged); go Done.
- Timeout:
  - The counter increments every cycle in WaitBusy and WaitDone.
  - When it reaches TimeoutCycles-1, go Error.
- Done (1 cycle):
  - ack of the granted port = 1; error=0.
  - last_grant := granted port; go Idle.
- Error (1 cycle):
  - ack of the granted port = 1; error=1; read_data unchanged.
  - last_grant updated; go Idle.
- Ack timing:
  - Ack is a single-cycle registered pulse, one cycle after sd_busy falls.
  - Minimum request-to-ack latency is 4 cycles: Idle→Issue→WaitBusy→WaitDone→Done.
- Re-arbitration: Idle re-arbitrates the cycle after ack. The requester must deassert its request in the ack cycle's next edge, or it is served again.
- Non-granted port: its requests are ignored until Idle; its inputs are not sampled.
- sd_addr and sd_write_data stay stable from Issue through Done/Error.
- Counter width: $clog2(TimeoutCycles)+1; saturates, never wraps.

Decomposition:
- Package sd_block_arbiter_pkg holds:
  - enum sd_block_arbiter_fsm_t {Idle, Issue, WaitBusy, WaitDone, Done, Error};
  - localparam port indices Port0=1'b0, Port1=1'b1.
- Sub-module sd_rr_picker (combinational):
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
  - Reused by later multi-requester memory arbiters.

Test Plan:
- Port 0 read alone:
  - Stimulus: p0_rd_en=1, p0_addr=9998; stub holds busy 20 cycles and returns DataBlock0.
  - Required: one sd_rd_en pulse with sd_addr=9998; p0_ack one cycle after busy falls; read_data=DataBlock0; error=0; p1_ack never rises.
- Port 1 write:
  - Stimulus: p1_wr_en=1, p1_addr=12000, p1_write_data=DataBlock1.
  - Required: sd_wr_en pulse; sd_write_data=DataBlock1 stable through Done; p1_ack pulses; read_data unchanged.
- Simultaneous requests:
  - Stimulus: both ports read at once (addr 9997 and 9996), both held after their first ack; then repeat.
  - Required: after reset the order is p0, p1, p0, p1 (alternating), and each sd_addr matches its port.
- Timeout:
  - Stimulus: TimeoutCycles=64 and a stub that never raises sd_busy.
  - Required: ack plus error=1 at cycle 64 after Issue; FSM returns to Idle; the next request completes normally.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 during WaitDone.
  - Required: all outputs 0 asynchronously; no ack; a port 0 request after release is served first.
- Both enables on one port:
  - Stimulus: p0_rd_en=p0_wr_en=1.
  - Required: only sd_rd_en pulses.

Source files
------------

// File: rtl/sd_block_arbiter_pkg.sv
// Shared types for the two-port SD block arbiter.
package sd_block_arbiter_pkg;

  typedef enum logic [2:0] {
    Idle,
    Issue,
    WaitBusy,
    WaitDone,
    Done,
    Error
  } sd_block_arbiter_fsm_t;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

endpackage

// File: rtl/sd_block_arbiter_if.sv
// Requester-side and controller-side signals of the SD block arbiter.
interface sd_block_arbiter_if #(
  parameter int BlockBits = 4096,
  parameter int AddrBits  = 32
);
  logic                 p0_rd_en;
  logic                 p0_wr_en;
  logic [AddrBits-1:0]  p0_addr;
  logic [BlockBits-1:0] p0_write_data;
  logic                 p0_ack;
  logic                 p1_rd_en;
  logic                 p1_wr_en;
  logic [AddrBits-1:0]  p1_addr;
  logic [BlockBits-1:0] p1_write_data;
  logic                 p1_ack;
  logic [BlockBits-1:0] read_data;
  logic                 error;
  logic                 sd_rd_en;
  logic                 sd_wr_en;
  logic [AddrBits-1:0]  sd_addr;
  logic [BlockBits-1:0] sd_write_data;
  logic [BlockBits-1:0] sd_read_data;
  logic                 sd_busy;

  modport slave (
    input  p0_rd_en, p0_wr_en, p0_addr, p0_write_data,
    input  p1_rd_en, p1_wr_en, p1_addr, p1_write_data,
    input  sd_read_data, sd_busy,
    output p0_ack, p1_ack, read_data, error,
    output sd_rd_en, sd_wr_en, sd_addr, sd_write_data
  );

  modport master (
    output p0_rd_en, p0_wr_en, p0_addr, p0_write_data,
    output p1_rd_en, p1_wr_en, p1_addr, p1_write_data,
    output sd_read_data, sd_busy,
    input  p0_ack, p1_ack, read_data, error,
    input  sd_rd_en, sd_wr_en, sd_addr, sd_write_data
  );
endinterface

// File: rtl/sd_rr_picker.sv
// Two-way round-robin pick: on a tie, the port that was not granted last wins.
module sd_rr_picker
  import sd_block_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = Port0;
    unique case (req)
      2'b01:   grant_idx = Port0;
      2'b10:   grant_idx = Port1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = Port0;
    endcase
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Shares one SD controller between two block requesters, with a watchdog
// that turns a hung controller transaction into an error-ack.
//
// state    | meaning
// Idle     | arbitrate; latch the winner's address, data and op
// Issue    | one-cycle sd_rd_en / sd_wr_en strobe; watchdog cleared
// WaitBusy | waiting for the controller to raise sd_busy
// WaitDone | waiting for sd_busy to fall; read block captured on exit
// Done     | ack pulse to the granted port, error=0
// Error    | watchdog expired: ack pulse with error=1
module sd_block_arbiter
  import sd_block_arbiter_pkg::*;
#(
  parameter int BlockBits     = 4096,
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 1_000_000
) (
  input logic clock,
  input logic reset_n,
  sd_block_arbiter_if.slave bus
);

  localparam int CntBits = $clog2(TimeoutCycles) + 1;
  localparam logic [CntBits-1:0] CntLast = CntBits'(TimeoutCycles - 1);

  sd_block_arbiter_fsm_t state_q, state_d;

  logic [1:0]           req;
  logic                 grant_valid, grant_idx, pick_read;
  logic [AddrBits-1:0]  pick_addr;
  logic [BlockBits-1:0] pick_wdata;
  logic                 grant_q, last_grant_q, is_read_q;
  logic [CntBits-1:0]   cnt_q, cnt_inc;
  logic                 timeout_hit;
  logic                 rd_en_d, wr_en_d, ack0_d, ack1_d, error_d, capture_d;
  logic                 rd_en_q, wr_en_q, ack0_q, ack1_q, error_q;
  logic [AddrBits-1:0]  addr_q;
  logic [BlockBits-1:0] wdata_q, read_data_q;

  // Both enables high on one port counts as a read.
  assign req        = {bus.p1_rd_en | bus.p1_wr_en, bus.p0_rd_en | bus.p0_wr_en};
  assign pick_read  = (grant_idx == Port1) ? bus.p1_rd_en      : bus.p0_rd_en;
  assign pick_addr  = (grant_idx == Port1) ? bus.p1_addr       : bus.p0_addr;
  assign pick_wdata = (grant_idx == Port1) ? bus.p1_write_data : bus.p0_write_data;

  sd_rr_picker u_picker (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Watchdog fires on the edge where the counter would reach its last value.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CntBits'(1);
  assign timeout_hit = (cnt_inc == CntLast);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= Idle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:     if (grant_valid) state_d = Issue;
      Issue:    state_d = WaitBusy;
      WaitBusy: if (timeout_hit) state_d = Error;
                else if (bus.sd_busy) state_d = WaitDone;
      WaitDone: if (timeout_hit) state_d = Error;
                else if (!bus.sd_busy) state_d = Done;
      Done:     state_d = Idle;
      Error:    state_d = Idle;
      default:  state_d = Idle;
    endcase
  end

  always_comb begin
    rd_en_d   = (state_q == Idle) && grant_valid && pick_read;
    wr_en_d   = (state_q == Idle) && grant_valid && !pick_read;
    ack0_d    = ((state_d == Done) || (state_d == Error)) && (grant_q == Port0);
    ack1_d    = ((state_d == Done) || (state_d == Error)) && (grant_q == Port1);
    error_d   = (state_d == Error);
    capture_d = (state_q == WaitDone) && (state_d == Done) && is_read_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      error_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      grant_q      <= Port0;
      is_read_q    <= 1'b0;
      last_grant_q <= Port1;
      cnt_q        <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      error_q <= error_d;
      if ((state_q == Idle) && grant_valid) begin
        addr_q    <= pick_addr;
        wdata_q   <= pick_wdata;
        grant_q   <= grant_idx;
        is_read_q <= pick_read;
      end
      if (capture_d) read_data_q <= bus.sd_read_data;
      if (state_q == Issue) cnt_q <= '0;
      else if ((state_q == WaitBusy) || (state_q == WaitDone)) cnt_q <= cnt_inc;
      if ((state_q == Done) || (state_q == Error)) last_grant_q <= grant_q;
    end
  end

  assign bus.sd_rd_en      = rd_en_q;
  assign bus.sd_wr_en      = wr_en_q;
  assign bus.sd_addr       = addr_q;
  assign bus.sd_write_data = wdata_q;
  assign bus.p0_ack        = ack0_q;
  assign bus.p1_ack        = ack1_q;
  assign bus.error         = error_q;
  assign bus.read_data     = read_data_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Scoreboard bench for sd_block_arbiter with a behavioural SD controller stub.
module tb_sd_block_arbiter;
  import sd_block_arbiter_pkg::*;

  localparam int BlockBits     = 4096;
  localparam int AddrBits      = 32;
  localparam int TimeoutCycles = 64;

  typedef logic [AddrBits-1:0]  addr_t;
  typedef logic [BlockBits-1:0] blk_t;

  typedef struct {
    logic  rd;
    addr_t addr;
    blk_t  wdata;
  } iss_exp_t;

  typedef struct {
    logic port;
    logic err;
    blk_t rdata;
    int   lat;   // 0: one cycle after busy falls, 1: TimeoutCycles after issue
  } ack_exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sd_block_arbiter_if #(.BlockBits(BlockBits), .AddrBits(AddrBits)) bus ();

  sd_block_arbiter #(
    .BlockBits     (BlockBits),
    .AddrBits      (AddrBits),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  iss_exp_t issue_q[$];
  ack_exp_t ack_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int issue_cyc = 0;
  int busy_len = 20;
  bit stub_hang = 1'b0;
  bit inflight = 1'b0;
  bit stable_bad = 1'b0;
  bit prev_strobe = 1'b0;
  addr_t cur_addr;
  blk_t  cur_wd;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic blk_t blk_for(input addr_t a);
    return {(BlockBits/32){a ^ 32'hC0DE_0000}};
  endfunction

  task automatic check(input bit ok, input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic port, input logic rd, input addr_t a, input blk_t wd,
                          input logic err, input blk_t rdata, input int lat);
    iss_exp_t i;
    ack_exp_t k;
    i.rd = rd; i.addr = a; i.wdata = wd;
    k.port = port; k.err = err; k.rdata = rdata; k.lat = lat;
    issue_q.push_back(i);
    ack_q.push_back(k);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(!bus.p0_ack && !bus.p1_ack && !bus.error, {tag, "_ack_err"},
          64'({bus.p0_ack, bus.p1_ack, bus.error}), 64'(0));
    check(!bus.sd_rd_en && !bus.sd_wr_en, {tag, "_strobes"},
          64'({bus.sd_rd_en, bus.sd_wr_en}), 64'(0));
    check(bus.sd_addr == '0, {tag, "_sd_addr"}, 64'(bus.sd_addr), 64'(0));
    check(bus.sd_write_data == '0, {tag, "_sd_write_data"}, bus.sd_write_data[63:0], 64'(0));
    check(bus.read_data == '0, {tag, "_read_data"}, bus.read_data[63:0], 64'(0));
  endtask

  // Holds each port's request until it has collected its quota of acks.
  task automatic serve(input int n0, input int n1, input logic rd0, input logic wr0,
                       input logic rd1, input logic wr1, input addr_t a0, input addr_t a1,
                       input blk_t w0, input blk_t w1);
    int g0 = 0;
    int g1 = 0;
    int budget = 0;
    @(negedge clock);
    if (n0 > 0) begin
      bus.p0_rd_en = rd0; bus.p0_wr_en = wr0; bus.p0_addr = a0; bus.p0_write_data = w0;
    end
    if (n1 > 0) begin
      bus.p1_rd_en = rd1; bus.p1_wr_en = wr1; bus.p1_addr = a1; bus.p1_write_data = w1;
    end
    while ((g0 < n0 || g1 < n1) && budget < 3000) begin
      @(negedge clock);
      budget++;
      if (bus.p0_ack) begin
        g0++;
        if (g0 >= n0) begin bus.p0_rd_en = 1'b0; bus.p0_wr_en = 1'b0; end
      end
      if (bus.p1_ack) begin
        g1++;
        if (g1 >= n1) begin bus.p1_rd_en = 1'b0; bus.p1_wr_en = 1'b0; end
      end
    end
    check(g0 == n0 && g1 == n1, "ack_count", 64'({g0[15:0], g1[15:0]}),
          64'({n0[15:0], n1[15:0]}));
  endtask

  // Controller stub: busy one half-cycle after the strobe, read block on the fall.
  initial begin
    addr_t a;
    bus.sd_busy = 1'b0;
    bus.sd_read_data = '0;
    forever begin
      @(negedge clock);
      if (reset_n && (bus.sd_rd_en || bus.sd_wr_en) && !stub_hang) begin
        a = bus.sd_addr;
        bus.sd_read_data = ~blk_for(a);
        bus.sd_busy = 1'b1;
        repeat (busy_len) @(negedge clock);
        bus.sd_read_data = blk_for(a);
        bus.sd_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes the controller or acks.
  initial begin
    iss_exp_t i;
    ack_exp_t k;
    int exp_cyc;
    bit strobe;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        strobe = bus.sd_rd_en || bus.sd_wr_en;
        if (strobe) begin
          check(!prev_strobe, "strobe_single_cycle", 64'(prev_strobe), 64'(0));
          if (issue_q.size() == 0) begin
            check(1'b0, "unexpected_issue", 64'(bus.sd_addr), 64'(0));
          end else begin
            i = issue_q.pop_front();
            check(bus.sd_rd_en == i.rd && bus.sd_wr_en == !i.rd, "issue_op",
                  64'({bus.sd_rd_en, bus.sd_wr_en}), 64'({i.rd, !i.rd}));
            check(bus.sd_addr == i.addr, "issue_addr", 64'(bus.sd_addr), 64'(i.addr));
            if (!i.rd)
              check(bus.sd_write_data == i.wdata, "issue_wdata",
                    bus.sd_write_data[63:0], i.wdata[63:0]);
          end
          inflight = 1'b1;
          stable_bad = 1'b0;
          cur_addr = bus.sd_addr;
          cur_wd = bus.sd_write_data;
          issue_cyc = cyc;
        end else if (inflight && (bus.sd_addr != cur_addr || bus.sd_write_data != cur_wd)) begin
          stable_bad = 1'b1;
        end
        prev_strobe = strobe;
        if (bus.p0_ack || bus.p1_ack) begin
          if (ack_q.size() == 0) begin
            check(1'b0, "unexpected_ack", 64'({bus.p0_ack, bus.p1_ack}), 64'(0));
          end else begin
            k = ack_q.pop_front();
            check(bus.p0_ack == !k.port && bus.p1_ack == k.port, "ack_port",
                  64'({bus.p1_ack, bus.p0_ack}), 64'({k.port, !k.port}));
            check(bus.error == k.err, "ack_error", 64'(bus.error), 64'(k.err));
            check(bus.read_data == k.rdata, "read_data", bus.read_data[63:0], k.rdata[63:0]);
            check(!stable_bad, "sd_bus_stable", 64'(stable_bad), 64'(0));
            exp_cyc = (k.lat == 0) ? fall_cyc + 1 : issue_cyc + TimeoutCycles;
            check(cyc == exp_cyc, "ack_latency", 64'(cyc), 64'(exp_cyc));
          end
          inflight = 1'b0;
        end
      end
    end
  end

  initial begin
    blk_t d1;
    int waited;
    d1 = {(BlockBits/32){32'hD47A_0001}};
    bus.p0_rd_en = 1'b0; bus.p0_wr_en = 1'b0; bus.p0_addr = '0; bus.p0_write_data = '0;
    bus.p1_rd_en = 1'b0; bus.p1_wr_en = 1'b0; bus.p1_addr = '0; bus.p1_write_data = '0;

    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Port 0 read alone
    busy_len = 20;
    push_txn(Port0, 1'b1, 32'd9998, '0, 1'b0, blk_for(32'd9998), 0);
    serve(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9998, '0, '0, '0);

    // Port 1 write: read_data keeps the previous read block
    push_txn(Port1, 1'b0, 32'd12000, d1, 1'b0, blk_for(32'd9998), 0);
    serve(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 32'd12000, '0, d1);

    // Simultaneous reads alternate p0, p1, p0, p1
    busy_len = 5;
    push_txn(Port0, 1'b1, 32'd9997, '0, 1'b0, blk_for(32'd9997), 0);
    push_txn(Port1, 1'b1, 32'd9996, '0, 1'b0, blk_for(32'd9996), 0);
    push_txn(Port0, 1'b1, 32'd9997, '0, 1'b0, blk_for(32'd9997), 0);
    push_txn(Port1, 1'b1, 32'd9996, '0, 1'b0, blk_for(32'd9996), 0);
    serve(2, 2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd9997, 32'd9996, '0, '0);

    // Controller never goes busy: error-ack, then a normal transaction
    stub_hang = 1'b1;
    push_txn(Port0, 1'b1, 32'd500, '0, 1'b1, blk_for(32'd9996), 1);
    serve(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd500, '0, '0, '0);
    stub_hang = 1'b0;
    push_txn(Port0, 1'b1, 32'd501, '0, 1'b0, blk_for(32'd501), 0);
    serve(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd501, '0, '0, '0);

    // Reset during WaitDone of a port 1 read; no ack may follow
    busy_len = 20;
    begin
      iss_exp_t i;
      i.rd = 1'b1; i.addr = 32'd700; i.wdata = '0;
      issue_q.push_back(i);
    end
    @(negedge clock);
    bus.p1_rd_en = 1'b1; bus.p1_addr = 32'd700;
    waited = 0;
    while (!bus.sd_busy && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check(bus.sd_busy, "busy_seen_before_reset", 64'(bus.sd_busy), 64'(1));
    repeat (3) @(negedge clock);
    bus.p1_rd_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_outputs_zero("midop_reset");
    inflight = 1'b0;
    waited = 0;
    while (bus.sd_busy && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Both request after reset: port 0 must be served first
    push_txn(Port0, 1'b1, 32'd800, '0, 1'b0, blk_for(32'd800), 0);
    push_txn(Port1, 1'b1, 32'd801, '0, 1'b0, blk_for(32'd801), 0);
    serve(1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd800, 32'd801, '0, '0);

    // Both enables on port 0 behave as a read
    push_txn(Port0, 1'b1, 32'd900, '0, 1'b0, blk_for(32'd900), 0);
    serve(1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd900, '0, {(BlockBits/32){32'h5555_AAAA}}, '0);

    repeat (5) @(negedge clock);
    check(ack_q.size() == 0 && issue_q.size() == 0, "scoreboard_drained",
          64'({ack_q.size(), issue_q.size()}), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
